// File: rtl/bcd_seq_adder_pkg.sv
// -----------------------------------------------------------------------------
// bcd_seq_adder_pkg
// Shared definitions for the sequential multi-digit BCD adder:
//   - state_t   : sequencer states (IDLE, RUN, FIN)
//   - BCD_MAX   : largest legal BCD digit value
//   - BCD_RADIX : decimal radix used for the carry correction
// -----------------------------------------------------------------------------
package bcd_seq_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam int BCD_MAX   = 9;
  localparam int BCD_RADIX = 10;

endpackage

// File: rtl/bcd_seq_adder_digit_slice.sv
// -----------------------------------------------------------------------------
// bcd_digit_slice
// Combinational single-digit decimal adder.
// Ports:
//   a[3:0], b[3:0] : BCD digits (assumed legal, 0..9)
//   cin            : decimal carry in
//   d[3:0]         : BCD sum digit
//   cout           : decimal carry out
// -----------------------------------------------------------------------------
module bcd_digit_slice
  import bcd_seq_adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);

  // Five bits are enough for the worst case 9 + 9 + 1 = 19.
  logic [4:0] w_sum;
  logic [4:0] w_adj;

  assign w_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign w_adj = w_sum - 5'(BCD_RADIX);

  always_comb begin
    d    = w_sum[3:0];
    cout = 1'b0;
    if (w_sum > 5'(BCD_MAX)) begin
      d    = w_adj[3:0];
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_seq_adder.sv
// -----------------------------------------------------------------------------
// bcd_seq_adder
// Adds two NDIG-digit packed BCD operands one digit per clock, LSD first,
// using a single shared bcd_digit_slice.
// Ports:
//   CLK          : clock, rising edge
//   nRST         : asynchronous active-low reset
//   START        : request, sampled only in IDLE
//   A, B         : packed BCD operands, digit 0 at [3:0]
//   BUSY         : high while digits are being processed (RUN)
//   DONE         : one-cycle pulse, RESULT/COUT/ERR valid
//   RESULT       : packed BCD sum mod 10^NDIG (held until next success)
//   COUT         : decimal carry out of the top digit
//   ERR          : last accepted request had a nibble > 9
//   o_dbg_state  : current sequencer state, for observation
// Handshake: START is a level sampled on a rising edge only while IDLE; any
// START seen in RUN or FIN is dropped (no queueing). DONE is asserted for the
// single FIN cycle that follows every accepted request, good or bad.
// -----------------------------------------------------------------------------
module bcd_seq_adder
  import bcd_seq_adder_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              START,
  input  logic [4*NDIG-1:0] A,
  input  logic [4*NDIG-1:0] B,
  output logic              BUSY,
  output logic              DONE,
  output logic [4*NDIG-1:0] RESULT,
  output logic              COUT,
  output logic              ERR,
  output state_t            o_dbg_state
);

  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [W-1:0]    r_result;
  logic            r_cout;
  logic            r_err;

  logic            w_bad;
  logic            w_last;
  logic [3:0]      w_d;
  logic            w_c;
  logic [W+3:0]    w_acc_wide;
  logic [W-1:0]    w_acc_next;

  // Operand legality: any nibble above 9 in either operand.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if ((A[4*i +: 4] > 4'(BCD_MAX)) || (B[4*i +: 4] > 4'(BCD_MAX)))
        w_bad = 1'b1;
    end
  end

  bcd_digit_slice u_slice (
    .a    (r_a[3:0]),
    .b    (r_b[3:0]),
    .cin  (r_carry),
    .d    (w_d),
    .cout (w_c)
  );

  // New digit enters at the MSD end; after NDIG shifts digit 0 sits at [3:0].
  // The wide concatenation keeps this legal for NDIG = 1.
  assign w_acc_wide = {w_d, r_acc};
  assign w_acc_next = w_acc_wide[W+3:4];
  assign w_last     = (r_idx == IW'(NDIG - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (START) w_next = w_bad ? S_FIN : S_RUN;
      S_RUN:   if (w_last) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_a     <= A;
            r_b     <= B;
            r_acc   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_err   <= w_bad;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_acc   <= w_acc_next;
          r_carry <= w_c;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_result <= w_acc_next;
            r_cout   <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY        = (r_state == S_RUN);
  assign DONE        = (r_state == S_FIN);
  assign RESULT      = r_result;
  assign COUT        = r_cout;
  assign ERR         = r_err;
  assign o_dbg_state = r_state;

endmodule
